// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU: signed or unsigned operands,
// HI = remainder, LO = quotient, with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for DivIn; operands latched and made non-negative on accept
// RUN   | one restoring step per cycle, WIDTH steps total
// FIX   | apply quotient/remainder signs and load result registers
// DONE  | operation finished; DivStop pulses in the following cycle
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             DivIn,
    input  logic             IsSigned,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] resultHigh,
    output logic [WIDTH-1:0] resultLow,
    output logic             DivStop,
    output logic             DivZero,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] b_abs;
    logic             sign_q, sign_r;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs_in, b_abs_in;
    logic [WIDTH+1:0] rem_sh, trial;
    logic             take;

    always_comb begin
        a_neg    = IsSigned & A[WIDTH-1];
        b_neg    = IsSigned & B[WIDTH-1];
        a_abs_in = a_neg ? -A : A;
        b_abs_in = b_neg ? -B : B;
    end

    // Shifted remainder can reach 2*|B|-1, so the trial needs one spare bit for the borrow.
    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        trial  = rem_sh - {2'b00, b_abs};
        take   = ~trial[WIDTH+1];
    end

    always_ff @(posedge clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (DivIn) state_nxt = (B == '0) ? DONE : RUN;
            RUN:  if (count == CW'(1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (Reset) begin
            count      <= '0;
            rem        <= '0;
            quo        <= '0;
            b_abs      <= '0;
            sign_q     <= 1'b0;
            sign_r     <= 1'b0;
            resultHigh <= '0;
            resultLow  <= '0;
            DivStop    <= 1'b0;
            DivZero    <= 1'b0;
        end else begin
            DivStop <= (state == DONE);
            case (state)
                IDLE: begin
                    if (DivIn) begin
                        DivZero <= (B == '0);
                        b_abs   <= b_abs_in;
                        rem     <= '0;
                        quo     <= a_abs_in;
                        sign_q  <= a_neg ^ b_neg;
                        sign_r  <= a_neg;
                        count   <= CW'(WIDTH);
                    end
                end
                RUN: begin
                    rem   <= take ? trial[WIDTH:0] : rem_sh[WIDTH:0];
                    quo   <= {quo[WIDTH-2:0], take};
                    count <= count - 1'b1;
                end
                FIX: begin
                    resultLow  <= sign_q ? -quo : quo;
                    resultHigh <= sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: a 32-bit and an 8-bit instance driven with directed and
// random operations, checked against an integer-arithmetic reference.
module tb_seq_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst32, din32, sg32, stop32, dz32, busy32;
    logic [31:0] a32, b32, hi32, lo32;
    logic        rst8, din8, sg8, stop8, dz8, busy8;
    logic [7:0]  a8, b8, hi8, lo8;

    seq_divider #(.WIDTH(32)) dut32 (
        .clk(clk), .Reset(rst32), .DivIn(din32), .IsSigned(sg32), .A(a32), .B(b32),
        .resultHigh(hi32), .resultLow(lo32), .DivStop(stop32), .DivZero(dz32), .busy(busy32)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .Reset(rst8), .DivIn(din8), .IsSigned(sg8), .A(a8), .B(b8),
        .resultHigh(hi8), .resultLow(lo8), .DivStop(stop8), .DivZero(dz8), .busy(busy8)
    );

    int          n_chk = 0;
    int          n_bad = 0;
    logic [31:0] exp_lo [2];
    logic [31:0] exp_hi [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division, which truncates toward zero and gives
    // the remainder the dividend's sign.
    function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input bit sgn, output logic [31:0] q, output logic [31:0] r);
        longint mask, sa, sb, tq, tr;
        mask = (longint'(1) << w) - 1;
        sa = longint'(a) & mask;
        sb = longint'(b) & mask;
        if (sgn) begin
            if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
            if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
        end
        q = '0;
        r = '0;
        if (sb != 0) begin
            tq = sa / sb;
            tr = sa % sb;
            q = 32'(tq & mask);
            r = 32'(tr & mask);
        end
    endfunction

    task automatic drive(input int w, input logic din, input logic [31:0] a,
                         input logic [31:0] b, input logic sgn);
        if (w == 32) begin din32 = din; a32 = a; b32 = b; sg32 = sgn; end
        else begin din8 = din; a8 = a[7:0]; b8 = b[7:0]; sg8 = sgn; end
    endtask

    task automatic set_rst(input int w, input logic v);
        if (w == 32) rst32 = v;
        else rst8 = v;
    endtask

    function automatic logic [31:0] get_lo(input int w);
        return (w == 32) ? lo32 : {24'b0, lo8};
    endfunction
    function automatic logic [31:0] get_hi(input int w);
        return (w == 32) ? hi32 : {24'b0, hi8};
    endfunction
    function automatic logic get_stop(input int w);
        return (w == 32) ? stop32 : stop8;
    endfunction
    function automatic logic get_dz(input int w);
        return (w == 32) ? dz32 : dz8;
    endfunction
    function automatic logic get_busy(input int w);
        return (w == 32) ? busy32 : busy8;
    endfunction

    task automatic op(input int w, input logic [31:0] a, input logic [31:0] b, input bit sgn,
                      input bit poke, input bit gap);
        logic [31:0] q, r, bm;
        int          idx, lat, extra;
        idx = (w == 32) ? 0 : 1;
        bm  = (w == 32) ? b : {24'b0, b[7:0]};
        model(w, a, b, sgn, q, r);
        if (bm != 0) begin
            exp_lo[idx] = q;
            exp_hi[idx] = r;
        end
        drive(w, 1'b1, a, b, sgn);
        @(posedge clk); #1;
        drive(w, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
        chk("busy_start", 32'(get_busy(w)), 32'(1));
        lat = 0;
        for (int k = 1; k <= w + 10; k++) begin
            @(posedge clk); #1;
            if (poke && k == 5) drive(w, 1'b1, 32'd1, 32'd1, 1'b0);
            if (poke && k == 6) drive(w, 1'b0, 32'd1, 32'd1, 1'b0);
            if (get_stop(w)) begin
                lat = k;
                break;
            end
        end
        drive(w, 1'b0, 32'd0, 32'd0, 1'b0);
        chk("latency", 32'(lat), (bm == 0) ? 32'd1 : 32'(w + 2));
        chk("lo", get_lo(w), exp_lo[idx]);
        chk("hi", get_hi(w), exp_hi[idx]);
        chk("divzero", 32'(get_dz(w)), 32'(bm == 0));
        chk("busy_idle", 32'(get_busy(w)), 32'(0));
        if (gap || poke) begin
            extra = 0;
            for (int k = 0; k < (poke ? w + 4 : 1); k++) begin
                @(posedge clk); #1;
                extra += int'(get_stop(w));
            end
            chk("extra_stop", 32'(extra), 32'(0));
            chk("busy_after", 32'(get_busy(w)), 32'(0));
            chk("divzero_hold", 32'(get_dz(w)), 32'(bm == 0));
            chk("lo_hold", get_lo(w), exp_lo[idx]);
        end
    endtask

    task automatic reset_mid(input int w);
        int idx, stops;
        idx = (w == 32) ? 0 : 1;
        drive(w, 1'b1, 32'd100, 32'd7, 1'b0);
        @(posedge clk); #1;
        drive(w, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        set_rst(w, 1'b1);
        @(posedge clk); #1;
        set_rst(w, 1'b0);
        chk("rst_lo", get_lo(w), 32'd0);
        chk("rst_hi", get_hi(w), 32'd0);
        chk("rst_busy", 32'(get_busy(w)), 32'd0);
        chk("rst_dz", 32'(get_dz(w)), 32'd0);
        stops = 0;
        for (int k = 0; k < w + 6; k++) begin
            @(posedge clk); #1;
            stops += int'(get_stop(w));
        end
        chk("rst_no_stop", 32'(stops), 32'd0);
        exp_lo[idx] = '0;
        exp_hi[idx] = '0;
    endtask

    initial begin
        logic [31:0] a, b, mask;
        int          w, sel;
        exp_lo = '{default: '0};
        exp_hi = '{default: '0};
        rst32 = 1'b1; rst8 = 1'b1;
        drive(32, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(8, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst32 = 1'b0; rst8 = 1'b0;
        foreach (exp_lo[i]) begin
            w = (i == 0) ? 32 : 8;
            chk("reset_lo", get_lo(w), 32'd0);
            chk("reset_hi", get_hi(w), 32'd0);
            chk("reset_stop", 32'(get_stop(w)), 32'd0);
            chk("reset_dz", 32'(get_dz(w)), 32'd0);
            chk("reset_busy", 32'(get_busy(w)), 32'd0);
        end

        op(32, 32'd100, 32'd7, 1'b0, 1'b0, 1'b1);
        op(32, 32'hFFFFFF9C, 32'd7, 1'b1, 1'b0, 1'b0);
        chk("neg100_div7_lo", lo32, 32'hFFFFFFF2);
        chk("neg100_div7_hi", hi32, 32'hFFFFFFFE);
        op(32, 32'd100, 32'hFFFFFFF9, 1'b1, 1'b0, 1'b0);
        op(32, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 1'b0);
        op(32, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1);
        chk("min_div_m1_lo", lo32, 32'h80000000);
        op(32, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
        op(32, 32'd5, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("div0_keeps_lo", lo32, 32'd14);
        chk("div0_keeps_hi", hi32, 32'd2);
        op(32, 32'd9, 32'd3, 1'b0, 1'b0, 1'b0);
        reset_mid(32);
        op(32, 32'd50, 32'd6, 1'b0, 1'b0, 1'b0);
        op(32, 32'd100, 32'd7, 1'b0, 1'b1, 1'b0);
        op(8, 32'd200, 32'd13, 1'b0, 1'b0, 1'b1);
        chk("w8_200_div13_lo", {24'b0, lo8}, 32'd15);
        op(8, 32'h80, 32'hFF, 1'b1, 1'b0, 1'b0);
        op(8, 32'd7, 32'd0, 1'b1, 1'b0, 1'b1);
        reset_mid(8);
        op(8, 32'd100, 32'd7, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 80; i++) begin
            w    = (i % 2 == 1) ? 8 : 32;
            mask = (w == 32) ? 32'hFFFFFFFF : 32'h000000FF;
            a    = $urandom & mask;
            sel  = $urandom_range(0, 9);
            case (sel)
                0:       b = 32'd0;
                1:       b = mask;
                2:       b = 32'd1;
                3:       b = $urandom_range(1, 15);
                default: b = $urandom & mask;
            endcase
            if ($urandom_range(0, 7) == 0) a = (mask >> 1) + 32'd1;
            op(w, a, b, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
